ifetch_queue: RTL and testbench

Instruction-fetch front end that drives the instruction memory's 8-bit word address and consumes its combinational 32-bit read data. Owns the fetch PC and fetches one word per cycle into a small circular queue. Presents up to two in-order {pc, inst} slots to the dual-issue decode stage. Handles decode back-pressure and branch/jump redirects with a full flush.

---
 rtl/ifq_pkg.sv | 13 +
 rtl/ifetch_queue_if.sv | 34 +++
 rtl/ifq_fifo.sv | 54 +++++
 rtl/ifetch_queue.sv | 99 +++++++++
 tb/tb_ifetch_queue.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/ifq_pkg.sv
// Shared widths and the queue entry layout for the instruction-fetch front end.
package ifq_pkg;

  localparam int IFQ_ADDR_W = 8;
  localparam int IFQ_DATA_W = 32;

  // One queued fetch: the word address it came from plus the instruction.
  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] inst;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Bus between the fetch queue, instruction memory and the dual-issue decode stage.
// master: the fetch queue side. slave: memory/decode side.
interface ifetch_queue_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] icache_a;
  logic [DATA_W-1:0] icache_rd;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [1:0]        deq;
  logic              inst0_valid;
  logic [DATA_W-1:0] inst0;
  logic [ADDR_W-1:0] pc0;
  logic              inst1_valid;
  logic [DATA_W-1:0] inst1;
  logic [ADDR_W-1:0] pc1;

  modport master (
    output icache_a,
    input  icache_rd,
    input  redirect_valid, redirect_pc, deq,
    output inst0_valid, inst0, pc0,
    output inst1_valid, inst1, pc1
  );

  modport slave (
    input  icache_a,
    output icache_rd,
    output redirect_valid, redirect_pc, deq,
    input  inst0_valid, inst0, pc0,
    input  inst1_valid, inst1, pc1
  );
endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer: one write port, two head-relative read ports (head, head+1),
// a flush that empties it, and an occupancy count. Callers never over-read.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter type entry_t = ifq_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  entry_t                     wr_data,
  input  logic [1:0]                 rd_cnt,
  output entry_t                     slot0,
  output entry_t                     slot1,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Pointer and occupancy bookkeeping; flush returns both pointers to zero.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + PW'(1);
      head  <= head + PW'(rd_cnt);
      count <= count - CW'(rd_cnt) + CW'(wr_en);
    end
  end

  // Entry storage; contents of empty slots are never observed as valid.
  // NOTE: the storage array has no reset, so it maps onto plain RAM/flops without a reset tree.
  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[tail] <= wr_data;
  end

  assign slot0 = mem[head];
  assign slot1 = mem[head + PW'(1)];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, fetches one word per cycle
// into ifq_fifo, presents two in-order slots to decode, clamps over-dequeue and
// flushes on redirect. Optional counters are enabled by macro IFQ_PERF_EN.
module ifetch_queue
  import ifq_pkg::*;
#(
  parameter int                ADDR_W   = IFQ_ADDR_W,
  parameter int                DATA_W   = IFQ_DATA_W,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  ifetch_queue_if.master bus
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]   perf_full_cyc,
  output logic [15:0]   perf_redirects
`endif
);

  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occ_after;
  logic [1:0]        deq_eff;
  logic              fetch;
  logic              full_block;
  entry_t            wr_data;
  entry_t            slot0;
  entry_t            slot1;

  // Clamp the dequeue request to what is actually queued, then decide whether
  // the slot freed this cycle (if any) leaves room to fetch.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    deq_eff = bus.deq;
    if (CW'(bus.deq) > count) deq_eff = count[1:0];
    occ_after  = count - CW'(deq_eff);
    fetch      = !bus.redirect_valid && (occ_after < CW'(QDEPTH));
    full_block = !bus.redirect_valid && !(occ_after < CW'(QDEPTH));
  end

  // Fetch PC: redirect wins, otherwise advance only when a word is enqueued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  pc <= RESET_PC;
    else if (bus.redirect_valid) pc <= bus.redirect_pc;
    else if (fetch)              pc <= pc + ADDR_W'(1);
  end

  assign wr_data.pc   = pc;
  assign wr_data.inst = bus.icache_rd;

  ifq_fifo #(
    .entry_t (entry_t),
    .DEPTH   (QDEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (bus.redirect_valid),
    .wr_en   (fetch),
    .wr_data (wr_data),
    .rd_cnt  (deq_eff),
    .slot0   (slot0),
    .slot1   (slot1),
    .count   (count)
  );

  assign bus.icache_a    = pc;
  assign bus.inst0_valid = (count != '0);
  assign bus.inst1_valid = (count > CW'(1));
  assign bus.inst0       = slot0.inst;
  assign bus.pc0         = slot0.pc;
  assign bus.inst1       = slot1.inst;
  assign bus.pc1         = slot1.pc;

`ifdef IFQ_PERF_EN
  // Saturating event counters: full-queue fetch stalls and accepted redirects.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_full_cyc  <= '0;
      perf_redirects <= '0;
    end else begin
      if (full_block && perf_full_cyc != 16'hFFFF) perf_full_cyc <= perf_full_cyc + 16'd1;
      if (bus.redirect_valid && perf_redirects != 16'hFFFF) perf_redirects <= perf_redirects + 16'd1;
    end
  end
`else
  logic unused_full_block;
  assign unused_full_block = full_block;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios followed by random
// deq/redirect traffic, all compared against a queue-based reference model.
module tb_ifetch_queue;

  localparam int          ADDR_W   = 8;
  localparam int          DATA_W   = 32;
  localparam int          QDEPTH   = 4;
  localparam logic [7:0]  RESET_PC = 8'h00;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } m_entry_t;

  logic clk;
  logic reset;
  logic [DATA_W-1:0] mem [256];

  ifetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef IFQ_PERF_EN
  logic [15:0] perf_full_cyc;
  logic [15:0] perf_redirects;
`endif

  ifetch_queue #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef IFQ_PERF_EN
    ,
    .perf_full_cyc  (perf_full_cyc),
    .perf_redirects (perf_redirects)
`endif
  );

  // Instruction memory: combinational read of whatever address the DUT drives.
  assign bus.icache_rd = mem[bus.icache_a];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  m_entry_t          mq [$];
  logic [ADDR_W-1:0] mpc;
  int                m_full_cyc;
  int                m_redirects;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    mpc         = RESET_PC;
    m_full_cyc  = 0;
    m_redirects = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs as currently driven.
  task automatic model_edge();
    int d;
    if (bus.redirect_valid) begin
      mq.delete();
      mpc = bus.redirect_pc;
      if (m_redirects < 16'hFFFF) m_redirects++;
    end else begin
      d = int'(bus.deq);
      if (d > mq.size()) d = mq.size();
      repeat (d) void'(mq.pop_front());
      if (mq.size() < QDEPTH) begin
        mq.push_back('{pc: mpc, inst: mem[mpc]});
        mpc = mpc + 8'd1;
      end else if (m_full_cyc < 16'hFFFF) begin
        m_full_cyc++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".icache_a"}, 64'(bus.icache_a), 64'(mpc));
    check({tag, ".v0"}, 64'(bus.inst0_valid), 64'(mq.size() >= 1));
    check({tag, ".v1"}, 64'(bus.inst1_valid), 64'(mq.size() >= 2));
    if (mq.size() >= 1) begin
      check({tag, ".pc0"},   64'(bus.pc0),   64'(mq[0].pc));
      check({tag, ".inst0"}, 64'(bus.inst0), 64'(mq[0].inst));
    end
    if (mq.size() >= 2) begin
      check({tag, ".pc1"},   64'(bus.pc1),   64'(mq[1].pc));
      check({tag, ".inst1"}, 64'(bus.inst1), 64'(mq[1].inst));
    end
`ifdef IFQ_PERF_EN
    check({tag, ".perf_full"}, 64'(perf_full_cyc),  64'(m_full_cyc));
    check({tag, ".perf_redir"}, 64'(perf_redirects), 64'(m_redirects));
`endif
  endtask

  // Advance one clock with current inputs, update the model, sample 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic [1:0] d, input logic rv, input logic [7:0] rpc);
    bus.deq            = d;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h1000_0000 + k;
    reset = 1'b0;
    drive(2'd0, 1'b0, 8'h00);
    model_reset();

    // Reset state, before any clock edge.
    #2;
    check_all("reset");
    check("reset.count_model", 64'(mq.size()), 64'd0);
    #8 reset = 1'b1;

    // Fill from reset with no dequeue, then one extra full cycle.
    for (int i = 0; i < 4; i++) step("fill");
    check("fill.pc1_is_1", 64'(bus.pc1), 64'd1);
    check("fill.icache_a_4", 64'(bus.icache_a), 64'd4);
    step("full_hold");

    // Drain two per cycle from a full queue.
    drive(2'd2, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step("drain2");

    // Build count=1 via redirect, then over-dequeue.
    drive(2'd0, 1'b1, 8'h20);
    step("clamp_redir");
    drive(2'd0, 1'b0, 8'h00);
    step("clamp_one");
    drive(2'd2, 1'b0, 8'h00);
    step("clamp_deq2");
    check("clamp.pc0", 64'(bus.pc0), 64'h21);

    // Redirect while full and decode tries to drain.
    drive(2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step("refill");
    drive(2'd2, 1'b1, 8'h40);
    step("redir_full");
    drive(2'd0, 1'b0, 8'h00);
    step("redir_next");
    check("redir.pc0_40", 64'(bus.pc0), 64'h40);

    // PC wrap with a steady single dequeue.
    drive(2'd0, 1'b1, 8'hFE);
    step("wrap_redir");
    drive(2'd1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) step("wrap");

    // Random traffic over random memory contents.
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    for (int i = 0; i < 400; i++) begin
      drive(2'($urandom_range(2)), ($urandom_range(15) == 0), 8'($urandom));
      step("rand");
    end

    // Asynchronous reset mid-stream with three entries queued.
    drive(2'd0, 1'b1, 8'h80);
    step("mid_redir");
    drive(2'd0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("mid_fill");
    check("mid.v1_before", 64'(bus.inst1_valid), 64'd1);
    #3 reset = 1'b0;
    model_reset();
    #1;
    check_all("mid_reset");
    #2 reset = 1'b1;
    drive(2'd1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
